// File: rtl/sdram_arb2_if.sv
// Avalon-MM single-word link between a master and a slave.
//   address/read/write/writedata/byteenable : command, master -> slave
//   waitrequest                             : stall, slave -> master
//   readdata/readdatavalid                  : read response, slave -> master
// modport master is the side that issues commands; modport slave is the side
// that receives them.
interface sdram_arb2_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sdram_arb2.sv
// Two-master round-robin arbiter in front of one SDRAM Avalon-MM slave.
// Ports:
//   clk_clk     : system clock, rising edge
//   reset_reset : synchronous active-high reset
//   m0, m1      : master-facing links (arbiter is their slave)
//   s           : SDRAM-facing link (arbiter is its master)
//   err_orphan  : sticky, a read response arrived with nothing pending
// Commands pass combinationally; read responses are steered by a FIFO of
// issuing-master IDs, so the slave must return reads in order.
module sdram_arb2 #(
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_PEND = 8
) (
  input  logic         clk_clk,
  input  logic         reset_reset,
  sdram_arb2_if.slave  m0,
  sdram_arb2_if.slave  m1,
  sdram_arb2_if.master s,
  output logic         err_orphan
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(MAX_PEND);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                last_q, last_d;
  logic                hold_q, hold_d;
  logic                hold_id_q, hold_id_d;
  logic                err_q, err_d;
  logic [MAX_PEND-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic              rd_ok, elig0, elig1;
  logic              win_vld, win_id;
  logic              win_rd, win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [BE_W-1:0]   win_be;
  logic              accept, push, pop, orphan, head;

  // Winner selection: a stalled grant is held; otherwise round-robin on eligibility.
  always_comb begin
    rd_ok   = count_q < CNT_W'(MAX_PEND);
    elig0   = m0.write | (m0.read & rd_ok);
    elig1   = m1.write | (m1.read & rd_ok);
    win_vld = 1'b0;
    win_id  = 1'b0;
    if (hold_q) begin
      win_vld = 1'b1;
      win_id  = hold_id_q;
    end else if (elig0 && elig1) begin
      win_vld = 1'b1;
      win_id  = ~last_q;
    end else if (elig0) begin
      win_vld = 1'b1;
      win_id  = 1'b0;
    end else if (elig1) begin
      win_vld = 1'b1;
      win_id  = 1'b1;
    end
    if (reset_reset) win_vld = 1'b0;

    win_rd    = win_id ? m1.read       : m0.read;
    win_wr    = win_id ? m1.write      : m0.write;
    win_addr  = win_id ? m1.address    : m0.address;
    win_wdata = win_id ? m1.writedata  : m0.writedata;
    win_be    = win_id ? m1.byteenable : m0.byteenable;

    accept = win_vld & ~s.waitrequest;
    push   = accept & win_rd;
    pop    = ~reset_reset & s.readdatavalid & (count_q != '0);
    orphan = ~reset_reset & s.readdatavalid & (count_q == '0);
    head   = fifo_q[rd_ptr_q];
  end

  assign s.address    = win_addr;
  assign s.writedata  = win_wdata;
  assign s.byteenable = win_be;
  assign s.read       = win_vld & win_rd;
  assign s.write      = win_vld & win_wr;

  assign m0.waitrequest   = ~(accept & ~win_id);
  assign m1.waitrequest   = ~(accept &  win_id);
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;
  assign m0.readdatavalid = pop & ~head;
  assign m1.readdatavalid = pop &  head;

  assign err_orphan = err_q;

  // Next-state: grant history, stall hold, ID FIFO and orphan flag.
  always_comb begin
    last_d    = last_q;
    hold_d    = hold_q;
    hold_id_d = hold_id_q;
    err_d     = err_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    if (accept) begin
      last_d = win_id;
      hold_d = 1'b0;
    end else if (win_vld) begin
      hold_d    = 1'b1;
      hold_id_d = win_id;
    end

    if (push) begin
      fifo_d[wr_ptr_q] = win_id;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (orphan) err_d = 1'b1;
  end

  // State register; last resets to 1 so m0 wins the first contention.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      last_q    <= 1'b1;
      hold_q    <= 1'b0;
      hold_id_q <= 1'b0;
      err_q     <= 1'b0;
      fifo_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      last_q    <= last_d;
      hold_q    <= hold_d;
      hold_id_q <= hold_id_d;
      err_q     <= err_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_sdram_arb2.sv
// Cycle-by-cycle vector bench for sdram_arb2: each record drives one clock
// cycle of inputs and lists the outputs expected in that same cycle.
module tb_sdram_arb2;

  localparam logic [1:0] I = 2'b00;  // idle
  localparam logic [1:0] R = 2'b10;  // read strobe
  localparam logic [1:0] W = 2'b01;  // write strobe

  typedef struct {
    logic        rst;
    logic [1:0]  c0;
    logic [23:0] a0;
    logic [1:0]  c1;
    logic [23:0] a1;
    logic        sw;
    logic        srdv;
    logic [15:0] srd;
    logic [1:0]  es;    // expected {s_read, s_write}
    logic [23:0] ea;    // expected s_address when a strobe is expected
    logic [1:0]  ewt;   // expected {m0_waitrequest, m1_waitrequest}
    logic [1:0]  ev;    // expected {m0_readdatavalid, m1_readdatavalid}
    logic        eerr;
  } vec_t;

  logic clk_clk = 1'b0;
  logic reset_reset;
  logic err_orphan;

  sdram_arb2_if m0_if ();
  sdram_arb2_if m1_if ();
  sdram_arb2_if s_if ();

  sdram_arb2 dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .err_orphan  (err_orphan)
  );

  always #5 clk_clk = ~clk_clk;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic [1:0] c0, logic [23:0] a0,
                              logic [1:0] c1, logic [23:0] a1, logic sw,
                              logic srdv, logic [15:0] srd, logic [1:0] es,
                              logic [23:0] ea, logic [1:0] ewt, logic [1:0] ev,
                              logic eerr);
    vec_t v;
    v.rst = rst; v.c0 = c0; v.a0 = a0; v.c1 = c1; v.a1 = a1;
    v.sw = sw; v.srdv = srdv; v.srd = srd;
    v.es = es; v.ea = ea; v.ewt = ewt; v.ev = ev; v.eerr = eerr;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic ok;
    @(posedge clk_clk);
    #1;
    reset_reset      = v.rst;
    m0_if.read       = v.c0[1];
    m0_if.write      = v.c0[0];
    m0_if.address    = v.a0;
    m1_if.read       = v.c1[1];
    m1_if.write      = v.c1[0];
    m1_if.address    = v.a1;
    s_if.waitrequest   = v.sw;
    s_if.readdatavalid = v.srdv;
    s_if.readdata      = v.srd;
    @(negedge clk_clk);
    ok = 1'b1;
    if ({s_if.read, s_if.write} !== v.es) ok = 1'b0;
    if ((v.es != 2'b00) && (s_if.address !== v.ea)) ok = 1'b0;
    if ({m0_if.waitrequest, m1_if.waitrequest} !== v.ewt) ok = 1'b0;
    if ({m0_if.readdatavalid, m1_if.readdatavalid} !== v.ev) ok = 1'b0;
    if (err_orphan !== v.eerr) ok = 1'b0;
    if (v.ev[1] && (m0_if.readdata !== v.srd)) ok = 1'b0;
    if (v.ev[0] && (m1_if.readdata !== v.srd)) ok = 1'b0;
    if (v.es[0] && v.ewt == 2'b01 &&
        (s_if.writedata !== 16'hA0A0 || s_if.byteenable !== 2'b01)) ok = 1'b0;
    if (v.es[0] && v.ewt == 2'b10 &&
        (s_if.writedata !== 16'hB1B1 || s_if.byteenable !== 2'b10)) ok = 1'b0;
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL vec%0d: got rw=%b adr=%h wait=%b rdv=%b err=%b rd0=%h rd1=%h wd=%h be=%b, want rw=%b adr=%h wait=%b rdv=%b err=%b rd=%h",
               n_vec - 1, {s_if.read, s_if.write}, s_if.address,
               {m0_if.waitrequest, m1_if.waitrequest},
               {m0_if.readdatavalid, m1_if.readdatavalid}, err_orphan,
               m0_if.readdata, m1_if.readdata, s_if.writedata, s_if.byteenable,
               v.es, v.ea, v.ewt, v.ev, v.eerr, v.srd);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    m0_if.read = 1'b0; m0_if.write = 1'b0; m0_if.address = '0;
    m1_if.read = 1'b0; m1_if.write = 1'b0; m1_if.address = '0;
    m0_if.writedata = 16'hA0A0; m0_if.byteenable = 2'b01;
    m1_if.writedata = 16'hB1B1; m1_if.byteenable = 2'b10;
    s_if.waitrequest = 1'b0; s_if.readdatavalid = 1'b0; s_if.readdata = '0;

    //            rst c0  a0       c1  a1       sw srdv srd       es ea       ewt    ev     err
    // reset held with m0 reading: nothing reaches the slave
    vecs.push_back(mk(1, R, 24'h10,  I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 0));
    vecs.push_back(mk(1, R, 24'h10,  I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 0));
    // continuous write contention: m0, m1, m0, m1
    vecs.push_back(mk(0, W, 24'h100, W, 24'h200, 0, 0, 16'h0,    W, 24'h100, 2'b01, 2'b00, 0));
    vecs.push_back(mk(0, W, 24'h100, W, 24'h200, 0, 0, 16'h0,    W, 24'h200, 2'b10, 2'b00, 0));
    vecs.push_back(mk(0, W, 24'h100, W, 24'h200, 0, 0, 16'h0,    W, 24'h100, 2'b01, 2'b00, 0));
    vecs.push_back(mk(0, W, 24'h100, W, 24'h200, 0, 0, 16'h0,    W, 24'h200, 2'b10, 2'b00, 0));
    // m0 read stalled 3 cycles while m1 writes; grant held, then m1
    vecs.push_back(mk(0, R, 24'h30,  W, 24'h200, 1, 0, 16'h0,    R, 24'h30,  2'b11, 2'b00, 0));
    vecs.push_back(mk(0, R, 24'h30,  W, 24'h200, 1, 0, 16'h0,    R, 24'h30,  2'b11, 2'b00, 0));
    vecs.push_back(mk(0, R, 24'h30,  W, 24'h200, 1, 0, 16'h0,    R, 24'h30,  2'b11, 2'b00, 0));
    vecs.push_back(mk(0, R, 24'h30,  W, 24'h200, 0, 0, 16'h0,    R, 24'h30,  2'b01, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   W, 24'h200, 0, 0, 16'h0,    W, 24'h200, 2'b10, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'h3030, I, 24'h0,   2'b11, 2'b10, 0));
    // in-order routing: m0, m1, m0 reads returned at latency 3
    vecs.push_back(mk(0, R, 24'h10,  R, 24'h20,  0, 0, 16'h0,    R, 24'h10,  2'b01, 2'b00, 0));
    vecs.push_back(mk(0, R, 24'h30,  R, 24'h20,  0, 0, 16'h0,    R, 24'h20,  2'b10, 2'b00, 0));
    vecs.push_back(mk(0, R, 24'h30,  I, 24'h0,   0, 0, 16'h0,    R, 24'h30,  2'b01, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'h1111, I, 24'h0,   2'b11, 2'b10, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'h2222, I, 24'h0,   2'b11, 2'b01, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'h3333, I, 24'h0,   2'b11, 2'b10, 0));
    // orphan response: flag rises next cycle and sticks
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'hDEAD, I, 24'h0,   2'b11, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 1));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 1));
    // push and pop in the same cycle
    vecs.push_back(mk(0, I, 24'h0,   R, 24'h40,  0, 0, 16'h0,    R, 24'h40,  2'b10, 2'b00, 1));
    vecs.push_back(mk(0, R, 24'h50,  I, 24'h0,   0, 1, 16'h4444, R, 24'h50,  2'b01, 2'b01, 1));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'h5555, I, 24'h0,   2'b11, 2'b10, 1));
    // reset during an m1 stall with an m1 read in flight
    vecs.push_back(mk(0, I, 24'h0,   R, 24'h70,  0, 0, 16'h0,    R, 24'h70,  2'b10, 2'b00, 1));
    vecs.push_back(mk(0, I, 24'h0,   W, 24'h90,  1, 0, 16'h0,    W, 24'h90,  2'b11, 2'b00, 1));
    vecs.push_back(mk(1, R, 24'h60,  W, 24'h90,  1, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 1));
    vecs.push_back(mk(0, W, 24'h60,  W, 24'h90,  0, 0, 16'h0,    W, 24'h60,  2'b01, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 1, 16'hAAAA, I, 24'h0,   2'b11, 2'b00, 0));
    vecs.push_back(mk(0, I, 24'h0,   I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 1));
    foreach (vecs[i]) apply(vecs[i]);

    // Backpressure: fill the 8-deep ID FIFO from m0, then probe the full case.
    apply(mk(1, I, 24'h0, I, 24'h0, 0, 0, 16'h0, I, 24'h0, 2'b11, 2'b00, 1));
    apply(mk(1, I, 24'h0, I, 24'h0, 0, 0, 16'h0, I, 24'h0, 2'b11, 2'b00, 0));
    for (int k = 0; k < 8; k++) begin
      apply(mk(0, R, 24'h100 + 24'(k), I, 24'h0, 0, 0, 16'h0,
               R, 24'h100 + 24'(k), 2'b01, 2'b00, 0));
    end
    apply(mk(0, R, 24'h108, W, 24'h300, 0, 0, 16'h0,    W, 24'h300, 2'b10, 2'b00, 0));
    apply(mk(0, R, 24'h108, I, 24'h0,   0, 1, 16'h1234, I, 24'h0,   2'b11, 2'b10, 0));
    apply(mk(0, R, 24'h108, I, 24'h0,   0, 0, 16'h0,    R, 24'h108, 2'b01, 2'b00, 0));
    apply(mk(0, R, 24'h109, I, 24'h0,   0, 0, 16'h0,    I, 24'h0,   2'b11, 2'b00, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
